// File: rtl/stage_ii.sv
// stage_ii: radix-2^2 SDF FFT stage built around the BF2II butterfly.
// The upstream sample is sign-extended, optionally rotated by -j, then either
// passed into the feedback delay line (s=0) or combined with the delay-line
// output in an add/sub butterfly (s=1). The result is registered once.
// Optional feature macro: STAGE_II_SAT_EN (saturating butterfly and negation;
// when undefined all arithmetic wraps modulo 2^data_width).
module stage_ii #(
    parameter int data_width   = 14,
    parameter int add_g        = 1,
    parameter int shift_stages = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          s,
    input  logic                          t,
    input  logic [data_width-add_g-1:0]   prvs_r,
    input  logic [data_width-add_g-1:0]   prvs_i,
    output logic [data_width-1:0]         tonext_r,
    output logic [data_width-1:0]         tonext_i,
    output logic                          primed
);

    localparam int CW = $clog2(shift_stages + 1);

    typedef logic signed [data_width-1:0] word_t;

    localparam word_t WORD_MAX = {1'b0, {(data_width-1){1'b1}}};
    localparam word_t WORD_MIN = {1'b1, {(data_width-1){1'b0}}};
    localparam word_t WORD_ZERO = {data_width{1'b0}};
    localparam logic [CW-1:0] FULL_COUNT = CW'(shift_stages);

    // Two's-complement negation; the saturating build maps the most-negative
    // value to +max instead of letting it wrap back onto itself.
    function automatic word_t neg_fn(input word_t a);
`ifdef STAGE_II_SAT_EN
        if (a == WORD_MIN) begin
            return WORD_MAX;
        end else begin
            return -a;
        end
`else
        return -a;
`endif
    endfunction

    // Butterfly add (sub=0) or subtract (sub=1) at data_width precision.
    function automatic word_t addsub_fn(input word_t a, input word_t b, input logic sub);
`ifdef STAGE_II_SAT_EN
        logic signed [data_width:0] w;
        if (sub) begin
            w = {a[data_width-1], a} - {b[data_width-1], b};
        end else begin
            w = {a[data_width-1], a} + {b[data_width-1], b};
        end
        if (w[data_width] != w[data_width-1]) begin
            return w[data_width] ? WORD_MIN : WORD_MAX;
        end else begin
            return w[data_width-1:0];
        end
`else
        if (sub) begin
            return a - b;
        end else begin
            return a + b;
        end
`endif
    endfunction

    word_t          dl_re_r [shift_stages];
    word_t          dl_im_r [shift_stages];
    logic [CW-1:0]  cnt_r;
    logic           primed_r;

    word_t          xr_s, xi_s;
    word_t          xpr_s, xpi_s;
    word_t          from_re_s, from_im_s;
    word_t          next_re_s, next_im_s;
    word_t          toreg_re_s, toreg_im_s;
    logic [CW-1:0]  cnt_next_s;

    assign from_re_s = dl_re_r[shift_stages-1];
    assign from_im_s = dl_im_r[shift_stages-1];
    assign primed    = primed_r;

    // Input conditioning, optional -j rotation and the BF2II butterfly.
    always_comb begin
        xr_s       = word_t'($signed(prvs_r));
        xi_s       = word_t'($signed(prvs_i));
        xpr_s      = xr_s;
        xpi_s      = xi_s;
        next_re_s  = from_re_s;
        next_im_s  = from_im_s;
        toreg_re_s = xr_s;
        toreg_im_s = xi_s;
        if (s && t) begin
            xpr_s = xi_s;
            xpi_s = neg_fn(xr_s);
        end else begin
            xpr_s = xr_s;
            xpi_s = xi_s;
        end
        if (s) begin
            next_re_s  = addsub_fn(from_re_s, xpr_s, 1'b0);
            next_im_s  = addsub_fn(from_im_s, xpi_s, 1'b0);
            toreg_re_s = addsub_fn(from_re_s, xpr_s, 1'b1);
            toreg_im_s = addsub_fn(from_im_s, xpi_s, 1'b1);
        end else begin
            next_re_s  = from_re_s;
            next_im_s  = from_im_s;
            toreg_re_s = xpr_s;
            toreg_im_s = xpi_s;
        end
    end

    // Fill count advances on enabled cycles and sticks once the line is full.
    always_comb begin
        cnt_next_s = cnt_r;
        if (enable && (cnt_r != FULL_COUNT)) begin
            cnt_next_s = cnt_r + CW'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Feedback delay line: head takes toreg, oldest word feeds the butterfly.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < shift_stages; k++) begin
                dl_re_r[k] <= WORD_ZERO;
                dl_im_r[k] <= WORD_ZERO;
            end
        end else if (enable) begin
            dl_re_r[0] <= toreg_re_s;
            dl_im_r[0] <= toreg_im_s;
            for (int k = 1; k < shift_stages; k++) begin
                dl_re_r[k] <= dl_re_r[k-1];
                dl_im_r[k] <= dl_im_r[k-1];
            end
        end
    end

    // Fill counter and sticky primed flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r    <= {CW{1'b0}};
            primed_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_next_s;
            primed_r <= primed_r | (cnt_next_s == FULL_COUNT);
        end
    end

    // Output register updates every clock regardless of enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            tonext_r <= WORD_ZERO;
            tonext_i <= WORD_ZERO;
        end else begin
            tonext_r <= next_re_s;
            tonext_i <= next_im_s;
        end
    end

endmodule
